adc_ramp_counter: RTL and testbench
===================================

Name: adc_ramp_counter

Overview:
Parametrised conversion counter for the column-parallel single-slope ADC.
On a start pulse it runs one conversion from a start value to a terminal value, then pulses done.
Counting can pause (hold), run up or down, or be aborted.
Publishes binary and Gray-coded counts on the same edge, so column latches can sample the Gray bus glitch-free while the comparator ramps.

Parameters:
width, 8, bit width of count and gray outputs.
max_count, 2**width-1, terminal value for up-count and start value for down-count; legal range 1 .. 2**width-1.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a conversion
abort  input  1  terminate the running conversion without done
down  input  1  direction, sampled only on an accepted start: 0 = up, 1 = down
hold  input  1  freeze count while converting
count  output  width  registered binary count
gray  output  width  registered Gray code of count
busy  output  1  high while in COUNT
done  output  1  one-cycle pulse when a conversion completes

Behaviour:
- States: IDLE, COUNT, DONE. All outputs are registered.
- Reset, at any edge with reset=1 and in any state: state=IDLE, count=0, gray=0, busy=0, done=0, latched direction=up. Reset overrides every other input, including during an active conversion.
- gray = count ^ (count >> 1) at all times. It is registered alongside count, with no extra latency.
- Terminal value: max_count when up, 0 when down.

IDLE:
- count holds its last value; busy=0; done=0.
- start=1 with abort=0: latch down; count loads 0 (up) or max_count (down); state goes to COUNT; busy=1 on the same edge.
- start=1 with abort=1: stays IDLE, nothing changes.

COUNT, with the following priority:
- abort=1: state goes to IDLE, busy=0, count holds, no done pulse.
- Else hold=1: count and gray hold, state stays COUNT. This applies at the terminal value too.
- Else count==terminal: state goes to DONE, done=1, busy=0, count holds the terminal value.
- Else count steps by +1 (up) or -1 (down).
- start is ignored in COUNT. down is ignored after launch.

DONE:
- Lasts exactly one cycle (done=1), then returns to IDLE with done=0.
- start and abort are ignored here. A start must be reissued in IDLE.

Timing and range:
- Un-held conversion: busy is high for max_count+1 cycles, with count presenting each value once. done rises on the following edge.
- Each hold cycle extends busy by one cycle.
- Count never wraps: it stops at the terminal value, so no overflow or underflow occurs in either direction.
- count keeps the final or aborted value until the next start or reset, so it can be read back after a conversion.

Test Plan:
- Up conversion (width=4, max_count=9): reset, then a start pulse with down=0 -> count 0,1,...,9 on consecutive cycles; gray 0,1,3,2,6,7,5,4,12,13; busy high 10 cycles; then done=1 for 1 cycle with count=9; then IDLE, done=0, count stays 9.
- Down conversion (same parameters): start with down=1 -> count 9,8,...,0; gray 13,12,4,...,1,0; done pulses once with count=0. Toggling down mid-conversion has no effect.
- Hold: up conversion with hold=1 for 3 cycles while count=4 -> count stays 4, gray stays 6, busy stays 1; done arrives 3 cycles later than in the un-held case. Hold at count=9 delays done until hold drops.
- Abort: abort=1 while count=5 -> next edge busy=0, count=5, no done pulse ever. A new start then begins at 0.
- Reset mid-operation: reset=1 while count=7 -> next edge count=0, gray=0, busy=0, done=0. Reset asserted on the same edge as done also yields done=0.
- Ignored starts: start during COUNT leaves the sequence unchanged. start during the DONE cycle launches nothing. start with abort in IDLE stays IDLE with count unchanged. Width=8 with default max_count=255 reaches 255 (gray 128) with no wrap.

Source files
------------

// File: rtl/adc_ramp_counter.sv
// Conversion counter for the column-parallel single-slope ADC.
// One start launches a conversion that counts from the start value to the
// terminal value (up: 0 -> max_count, down: max_count -> 0), then pulses done.
// Binary and Gray counts are updated on the same edge so that column latches
// can sample the Gray bus safely while the comparator ramps.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; count keeps the last result
// COUNT | conversion running; busy=1; abort > hold > terminal > step
// DONE  | one-cycle completion pulse, then back to IDLE
module adc_ramp_counter #(
  parameter int width     = 8,
  parameter int max_count = 2**width - 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             down,
  input  logic             hold,
  output logic [width-1:0] count,
  output logic [width-1:0] gray,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [width-1:0] top_val = width'(max_count);
  localparam logic [width-1:0] one     = width'(1);

  state_t           state;
  logic             dir_down;
  logic [width-1:0] step_val;
  logic [width-1:0] term_val;

  function automatic logic [width-1:0] to_gray(input logic [width-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Next count value and terminal value for the latched direction.
  always_comb begin
    step_val = count + one;
    term_val = top_val;
    if (dir_down) begin
      step_val = count - one;
      term_val = '0;
    end
  end

  // Conversion state machine; every output is registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      gray     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      dir_down <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          busy <= 1'b0;
          if (start && !abort) begin
            dir_down <= down;
            busy     <= 1'b1;
            state    <= COUNT;
            if (down) begin
              count <= top_val;
              gray  <= to_gray(top_val);
            end else begin
              count <= '0;
              gray  <= '0;
            end
          end
        end
        COUNT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (hold) begin
            state <= COUNT;
          end else if (count == term_val) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            count <= step_val;
            gray  <= to_gray(step_val);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_ramp_counter.sv
// Directed bench for adc_ramp_counter: a width=4/max_count=9 instance for the
// sequencing cases and a width=8 default instance for the full-range case.
module tb_adc_ramp_counter;

  logic       clk = 1'b0;
  logic       reset, start, abort, down, hold;
  logic [3:0] count4, gray4;
  logic       busy4, done4;
  logic [7:0] count8, gray8;
  logic       busy8, done8;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] gtab [10] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12, 4'd13};

  adc_ramp_counter #(.width(4), .max_count(9)) dut4 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .down(down), .hold(hold),
    .count(count4), .gray(gray4), .busy(busy4), .done(done4)
  );

  adc_ramp_counter #(.width(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .down(down), .hold(hold),
    .count(count8), .gray(gray8), .busy(busy8), .done(done8)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // one rising edge, then settle away from it
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic launch(input logic dir);
    start = 1'b1;
    down  = dir;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; down = 1'b0; hold = 1'b0;
    tick(2);
    reset = 1'b0;
    check_val("rst_count", count4, 0);
    check_val("rst_gray", gray4, 0);
    check_val("rst_busy", busy4, 0);
    check_val("rst_done", done4, 0);

    // up conversion
    launch(1'b0);
    for (int i = 0; i < 10; i++) begin
      check_val("up_count", count4, i);
      check_val("up_gray", gray4, gtab[i]);
      check_val("up_busy", busy4, 1);
      check_val("up_nodone", done4, 0);
      tick();
    end
    check_val("up_done", done4, 1);
    check_val("up_done_busy", busy4, 0);
    check_val("up_done_count", count4, 9);
    tick();
    check_val("up_after_done", done4, 0);
    check_val("up_after_count", count4, 9);
    check_val("up_after_busy", busy4, 0);

    // down conversion, direction toggled mid-flight
    launch(1'b1);
    for (int i = 9; i >= 0; i--) begin
      check_val("dn_count", count4, i);
      check_val("dn_gray", gray4, gtab[i]);
      check_val("dn_busy", busy4, 1);
      down = ~down;
      tick();
    end
    down = 1'b0;
    check_val("dn_done", done4, 1);
    check_val("dn_done_count", count4, 0);
    tick();
    check_val("dn_after_done", done4, 0);

    // hold for 3 cycles at count=4
    launch(1'b0);
    tick(4);
    check_val("hold_pre", count4, 4);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("hold_count", count4, 4);
      check_val("hold_gray", gray4, 6);
      check_val("hold_busy", busy4, 1);
    end
    hold = 1'b0;
    tick();
    check_val("hold_resume", count4, 5);
    tick(4);
    check_val("hold_at9", count4, 9);
    check_val("hold_at9_nodone", done4, 0);
    tick();
    check_val("hold_done_late", done4, 1);
    tick();

    // hold at the terminal value delays done
    launch(1'b0);
    tick(9);
    check_val("thold_pre", count4, 9);
    hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_val("thold_count", count4, 9);
      check_val("thold_busy", busy4, 1);
      check_val("thold_nodone", done4, 0);
    end
    hold = 1'b0;
    tick();
    check_val("thold_done", done4, 1);
    tick();
    check_val("thold_after", done4, 0);

    // abort at count=5
    launch(1'b0);
    tick(5);
    check_val("ab_pre", count4, 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("ab_busy", busy4, 0);
    check_val("ab_count", count4, 5);
    check_val("ab_nodone", done4, 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_val("ab_never_done", done4, 0);
    end
    check_val("ab_hold_count", count4, 5);
    launch(1'b0);
    check_val("ab_restart", count4, 0);
    check_val("ab_restart_busy", busy4, 1);

    // reset mid-conversion at count=7
    tick(7);
    check_val("mrst_pre", count4, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("mrst_count", count4, 0);
    check_val("mrst_gray", gray4, 0);
    check_val("mrst_busy", busy4, 0);
    check_val("mrst_done", done4, 0);

    // reset on the edge that would raise done
    launch(1'b0);
    tick(9);
    check_val("drst_pre", count4, 9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("drst_done", done4, 0);
    check_val("drst_count", count4, 0);
    tick();
    check_val("drst_stay", done4, 0);

    // start ignored during COUNT and DONE, start+abort ignored in IDLE
    launch(1'b0);
    tick(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("ign_count", count4, 3);
    tick(6);
    check_val("ign_at9", count4, 9);
    tick();
    check_val("ign_done", done4, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("ign_done_start_busy", busy4, 0);
    check_val("ign_done_start_done", done4, 0);
    tick();
    check_val("ign_idle_busy", busy4, 0);
    check_val("ign_idle_count", count4, 9);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_val("sa_busy", busy4, 0);
    check_val("sa_count", count4, 9);
    tick(2);
    check_val("sa_still_idle", busy4, 0);

    // full range on the width=8 instance
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("w8_rst", count8, 0);
    launch(1'b0);
    check_val("w8_start", count8, 0);
    tick(255);
    check_val("w8_count", count8, 255);
    check_val("w8_gray", gray8, 128);
    check_val("w8_busy", busy8, 1);
    tick();
    check_val("w8_done", done8, 1);
    check_val("w8_done_count", count8, 255);
    tick(3);
    check_val("w8_nowrap", count8, 255);
    check_val("w8_idle", busy8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
